// File: rtl/md_iter_engine_pkg.sv
// rtl/md_iter_engine_pkg.sv - shared MDU op codes, FSM encoding and iteration count
package md_iter_engine_pkg;

  // MDUOp codes shared with the MDU front end
  localparam logic [3:0] MDU_MULT  = 4'h1;
  localparam logic [3:0] MDU_MULTU = 4'h2;
  localparam logic [3:0] MDU_DIV   = 4'h3;
  localparam logic [3:0] MDU_DIVU  = 4'h4;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // One iteration per operand bit
  localparam int unsigned MD_ITERS  = 32;
  localparam logic [4:0]  ITER_LAST = 5'(MD_ITERS - 1);

  function automatic logic op_valid(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// rtl/md_sign_fix.sv - combinational conditional two's complement negate (magnitude / sign fix)
module md_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  assign res_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/md_iter_engine.sv
// rtl/md_iter_engine.sv - iterative shift-add multiplier / restoring divider; optional div0 output under MD_DIV0_FLAG_EN
module md_iter_engine
  import md_iter_engine_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
`ifdef MD_DIV0_FLAG_EN
  ,
  output logic        div0_o
`endif
);

  logic [2:0]  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  // acc holds {product_hi, multiplier/product_lo} for mult, {remainder, quotient} for div
  logic [63:0] acc_q, acc_d;
  // multiplicand magnitude for mult, divisor magnitude for div
  logic [31:0] opnd_q, opnd_d;
  logic        sgn_q, sgn_d;
  logic        rsgn_q, rsgn_d;
  logic [4:0]  iter_q, iter_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_mul, is_signed;
  logic [31:0] mag_a, mag_b;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic [32:0] mul_sum;
  logic [32:0] div_tmp, div_diff;

  assign is_mul    = (op_q == MDU_MULT) || (op_q == MDU_MULTU);
  assign is_signed = (op_q == MDU_MULT) || (op_q == MDU_DIV);

  md_sign_fix #(.WIDTH(32)) u_mag_a (.val_i(a_q), .neg_i(is_signed & a_q[31]), .res_o(mag_a));
  md_sign_fix #(.WIDTH(32)) u_mag_b (.val_i(b_q), .neg_i(is_signed & b_q[31]), .res_o(mag_b));
  md_sign_fix #(.WIDTH(64)) u_prod  (.val_i(acc_q), .neg_i(sgn_q), .res_o(prod_fix));
  md_sign_fix #(.WIDTH(32)) u_quo   (.val_i(acc_q[31:0]), .neg_i(sgn_q), .res_o(quo_fix));
  md_sign_fix #(.WIDTH(32)) u_rem   (.val_i(acc_q[63:32]), .neg_i(rsgn_q), .res_o(rem_fix));

  // Next-state logic: FSM sequencing plus one multiply or divide step per ITER cycle
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    sgn_d   = sgn_q;
    rsgn_d  = rsgn_q;
    iter_d  = iter_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    // Mult: add multiplicand into the upper half when the multiplier LSB is set, then shift right
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    // Div: shift {rem, quo} left by one and trial-subtract; remainder stays below divisor so 33 bits suffice
    div_tmp  = acc_q[63:31];
    div_diff = div_tmp - {1'b0, opnd_q};
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i && op_valid(op_i)) begin
            op_d    = op_i;
            a_d     = a_i;
            b_d     = b_i;
            state_d = ST_PREP;
          end
        end
        ST_PREP: begin
          acc_d   = is_mul ? {32'd0, mag_b} : {32'd0, mag_a};
          opnd_d  = is_mul ? mag_a : mag_b;
          sgn_d   = is_signed & (a_q[31] ^ b_q[31]);
          rsgn_d  = is_signed & a_q[31];
          iter_d  = 5'd0;
          state_d = ST_ITER;
        end
        ST_ITER: begin
          if (is_mul) begin
            acc_d = {mul_sum, acc_q[31:1]};
          end else if (!div_diff[32]) begin
            acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
          end else begin
            acc_d = {div_tmp[31:0], acc_q[30:0], 1'b0};
          end
          iter_d = iter_q + 5'd1;
          if (iter_q == ITER_LAST) state_d = ST_FIX;
        end
        ST_FIX: begin
          if (is_mul) begin
            {hi_d, lo_d} = prod_fix;
          end else if (b_q != 32'd0) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
          state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      opnd_q  <= 32'd0;
      sgn_q   <= 1'b0;
      rsgn_q  <= 1'b0;
      iter_q  <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      sgn_q   <= sgn_d;
      rsgn_q  <= rsgn_d;
      iter_q  <= iter_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
  assign done_o = (state_q == ST_DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

`ifdef MD_DIV0_FLAG_EN
  assign div0_o = (state_q == ST_DONE) && !is_mul && (b_q == 32'd0);
`endif

endmodule

// File: tb/tb_md_iter_engine.sv
// tb/tb_md_iter_engine.sv - directed self-checking bench for md_iter_engine
module tb_md_iter_engine;

  localparam logic [3:0] OP_MULT = 4'h1, OP_MULTU = 4'h2, OP_DIV = 4'h3, OP_DIVU = 4'h4;
`ifdef MD_DIV0_FLAG_EN
  localparam int EXP_DIV0 = 1;
`else
  localparam int EXP_DIV0 = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        flush = 1'b0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;
  int          total = 0;
  int          bad = 0;

  md_iter_engine dut (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .flush_i(flush), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
`ifdef MD_DIV0_FLAG_EN
    , .div0_o(div0)
`endif
  );
`ifndef MD_DIV0_FLAG_EN
  assign div0 = 1'b0;
`endif

  always #5 clk = ~clk;

  // Issue one op and observe 40 cycles; c counts cycles after the acceptance edge T
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int dcyc, output int bcnt, output int dcnt, output int d0cnt,
                        output logic [31:0] h, output logic [31:0] l);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcyc = -1; bcnt = 0; dcnt = 0; d0cnt = 0; h = hi; l = lo;
    for (int c = 1; c <= 40; c++) begin
      if (busy) bcnt++;
      if (div0) d0cnt++;
      if (done) begin
        dcnt++;
        if (dcyc < 0) dcyc = c;
        h = hi; l = lo;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({busy, done, hi, lo} !== 66'd0) begin bad++;
      $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int dc, bc, dn, d0; logic [31:0] h, l;
    run_op(OP_MULT, 32'hFFFFFFFE, 32'h00000003, dc, bc, dn, d0, h, l);
    total++; if (dc !== 35) begin bad++; $display("FAIL mult_latency got %0d want 35", dc); end
    total++; if (bc !== 34) begin bad++; $display("FAIL mult_busy_cycles got %0d want 34", bc); end
    total++; if (dn !== 1) begin bad++; $display("FAIL mult_done_count got %0d want 1", dn); end
    total++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFFA) begin bad++; $display("FAIL mult_neg got %h_%h want ffffffff_fffffffa", h, l); end
    total++; if (d0 !== 0) begin bad++; $display("FAIL mult_div0 got %0d want 0", d0); end
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, dc, bc, dn, d0, h, l);
    total++; if ({h, l} !== 64'hFFFFFFFE_00000001) begin bad++; $display("FAIL multu_max got %h_%h want fffffffe_00000001", h, l); end
    run_op(OP_MULT, 32'h80000000, 32'h80000000, dc, bc, dn, d0, h, l);
    total++; if ({h, l} !== 64'h40000000_00000000) begin bad++; $display("FAIL mult_minmin got %h_%h want 40000000_00000000", h, l); end
  endtask

  task automatic test_div();
    int dc, bc, dn, d0; logic [31:0] h, l;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, dc, bc, dn, d0, h, l);
    total++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFFD) begin bad++; $display("FAIL div_neg_dividend got %h_%h want ffffffff_fffffffd", h, l); end
    total++; if (dc !== 35) begin bad++; $display("FAIL div_latency got %0d want 35", dc); end
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, dc, bc, dn, d0, h, l);
    total++; if ({h, l} !== 64'h00000001_FFFFFFFD) begin bad++; $display("FAIL div_neg_divisor got %h_%h want 00000001_fffffffd", h, l); end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, dc, bc, dn, d0, h, l);
    total++; if ({h, l} !== 64'h00000000_80000000) begin bad++; $display("FAIL div_overflow got %h_%h want 00000000_80000000", h, l); end
    run_op(OP_DIVU, 32'd7, 32'd2, dc, bc, dn, d0, h, l);
    total++; if ({h, l} !== 64'h00000001_00000003) begin bad++; $display("FAIL divu_7_2 got %h_%h want 00000001_00000003", h, l); end
    run_op(OP_DIVU, 32'd5, 32'd0, dc, bc, dn, d0, h, l);
    total++; if (dc !== 35) begin bad++; $display("FAIL div0_latency got %0d want 35", dc); end
    total++; if ({h, l} !== 64'h00000001_00000003) begin bad++; $display("FAIL div0_hold got %h_%h want 00000001_00000003", h, l); end
    total++; if (d0 !== EXP_DIV0) begin bad++; $display("FAIL div0_flag_cycles got %0d want %0d", d0, EXP_DIV0); end
  endtask

  task automatic test_invalid_op();
    int bc = 0, dn = 0;
    @(negedge clk);
    op = 4'hF; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) bc++;
      if (done) dn++;
      @(negedge clk);
    end
    total++; if (bc !== 0 || dn !== 0) begin bad++; $display("FAIL invalid_op got busy=%0d done=%0d want 0/0", bc, dn); end
    total++; if ({hi, lo} !== 64'h00000001_00000003) begin bad++; $display("FAIL invalid_op_hold got %h_%h want 00000001_00000003", hi, lo); end
  endtask

  task automatic test_flush();
    int dc, bc, dn, d0; logic [31:0] h, l;
    @(negedge clk);
    op = OP_MULT; a = 32'd6; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL flush_idle got busy=%b done=%b want 0/0", busy, done); end
    total++; if ({hi, lo} !== 64'h00000001_00000003) begin bad++; $display("FAIL flush_hold got %h_%h want 00000001_00000003", hi, lo); end
    run_op(OP_MULTU, 32'd6, 32'd7, dc, bc, dn, d0, h, l);
    total++; if (dc !== 35 || dn !== 1) begin bad++; $display("FAIL flush_restart got cycle=%0d dones=%0d want 35/1", dc, dn); end
    total++; if ({h, l} !== 64'd42) begin bad++; $display("FAIL flush_restart_val got %h_%h want 00000000_0000002a", h, l); end
  endtask

  task automatic test_ignored_start();
    int dc = -1, dn = 0;
    @(negedge clk);
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5) begin op = OP_MULT; a = 32'd5; b = 32'd5; start = 1'b1; end
      else start = 1'b0;
      if (done) begin dn++; if (dc < 0) dc = c; end
      @(negedge clk);
    end
    total++; if (dn !== 1 || dc !== 35) begin bad++; $display("FAIL ignored_start got dones=%0d cycle=%0d want 1/35", dn, dc); end
    total++; if ({hi, lo} !== 64'h00000002_0000000E) begin bad++; $display("FAIL ignored_start_val got %h_%h want 00000002_0000000e", hi, lo); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    op = OP_DIVU; a = 32'd9; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (34) @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_first_done got %b want 1", done); end
    op = OP_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_not_in_done got busy=%b want 0", busy); end
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
    repeat (34) @(negedge clk);
    total++; if (done !== 1'b1 || {hi, lo} !== 64'd12) begin bad++;
      $display("FAIL b2b_second got done=%b %h_%h want 1 00000000_0000000c", done, hi, lo); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    op = OP_DIV; a = 32'd50; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if ({busy, done, hi, lo} !== 66'd0) begin bad++;
      $display("FAIL async_reset got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    begin
      int act = 0;
      for (int c = 0; c < 40; c++) begin
        if (busy || done) act++;
        @(negedge clk);
      end
      total++; if (act !== 0) begin bad++; $display("FAIL reset_wait got active=%0d want 0", act); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_invalid_op();
    test_flush();
    test_ignored_start();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_iter_engine.md
# md_iter_engine

Iterative multiply/divide datapath sitting directly downstream of the MDU front end: it accepts one MULT/MULTU/DIV/DIVU request with operands and computes the 64-bit result over a fixed number of cycles. It uses a shift-add multiplier and a restoring divider instead of single-cycle `*`, `/` and `%`. It returns HI/LO with a one-cycle done pulse, so the MDU keeps only HI/LO and busy tracking. It has one datapath and one FSM, and handles one operation at a time.

## Interface
- No parameters; width fixed at 32 (operands), 64 (result).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  request strobe, sampled only in IDLE
- op  in  4  MDUOp code (mult, multu, div, divu from shared constants); other codes with start are ignored
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- flush  in  1  kill in-flight operation (exception/eret)
- busy  out  1  high from the cycle after an accepted start through FIX
- done  out  1  one-cycle pulse; hi/lo valid the same cycle
- hi  out  32  product[63:32] or remainder
- lo  out  32  product[31:0] or quotient

## Operation
- FSM states and transitions:
  - IDLE: on start with a valid op, latch op, a and b, then go to PREP.
  - PREP: take magnitudes (signed ops), record result signs, clear the accumulator, set iter=0, then go to ITER.
  - ITER: 32 cycles. Mult shifts the multiplier right and adds the multiplicand to the accumulator when bit0=1. Div shifts the remainder/quotient left, trial-subtracts the divisor, and keeps the result if it is non-negative. iter increments; at iter==31 go to FIX.
  - FIX: apply sign correction and register hi/lo, then go to DONE.
  - DONE: done=1, then go to IDLE.
- Signed mult: product negated iff a[31]^b[31]; full 64-bit two's complement result.
- Signed div: quotient truncates toward zero; remainder takes the dividend's sign. 0x80000000 / -1 gives lo=0x80000000, hi=0 (natural 32-bit wrap).
- Divide by zero: hi/lo keep their previous values, done still pulses, and latency is unchanged.
- Unsigned ops do no sign handling; magnitudes are the raw operands.
- start is ignored in any state other than IDLE.
- An invalid op code with start stays in IDLE, with no busy and no done.
- hi/lo change only on the FIX to DONE edge. Otherwise they hold their last result.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0; FSM in IDLE; iter=0.
- start accepted at edge T:
  - PREP runs in cycle T+1.
  - ITER runs in cycles T+2..T+33.
  - FIX runs in cycle T+34.
  - done=1 and hi/lo are valid in cycle T+35.
  - busy=1 in cycles T+1..T+34.
- Back-to-back: start may be asserted in the done cycle. It is not accepted, because the FSM is in DONE; the earliest acceptance is the cycle after done.
- flush has priority over everything except reset. Asserted in any state, it returns the FSM to IDLE at the next edge with busy=0, done=0, and hi/lo unchanged. A flush in the DONE cycle does not retract done.
- reset asserted mid-operation: all outputs return to their reset values asynchronously. After release, the engine waits for a new start.

## Configuration
- MD_DIV0_FLAG_EN: when defined, adds output `div0` (1 bit, reset 0).
  - div0 pulses high together with done when a DIV/DIVU completes with b==0.
  - div0 stays 0 for all other operations.
  - When undefined, the port and its logic are absent; hi/lo behaviour is identical either way.

## Structure
- Shared constants package/header (existing const file) holds:
  - the MDUOp codes for mult, multu, div, divu;
  - the FSM state encoding (IDLE, PREP, ITER, FIX, DONE);
  - the iteration count 32.
- One natural sub-module, `md_sign_fix`: combinational magnitude/negate helper used in PREP and FIX. Everything else lives in md_iter_engine.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=0x00000003: done at T+35 with hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for exactly 34 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2: lo=3, hi=1.
- DIVU with b=0 after a prior result hi=1, lo=3: done pulses at T+35 and hi/lo stay 1/3. With MD_DIV0_FLAG_EN, div0=1 in that cycle only.
- flush at T+10 of a MULT: busy=0 next cycle, no done, hi/lo unchanged. A start one cycle later is accepted and completes normally.
- reset driven low at T+20 of a DIV: busy, done, hi and lo go to 0 immediately without a clock edge. A start ignored mid-operation (T+5) produces exactly one done.
